// File: rtl/sat_arith_pkg.sv
// sat_arith_pkg: shared constants and helper for W-bit two's-complement
// saturating arithmetic.
//   W        default sample/result width
//   SAT_MAX  most positive representable value, 2^(W-1)-1
//   SAT_MIN  most negative representable value, -2^(W-1)
//   sat_add  returns {sum, ovf} for a saturating W-bit add
package sat_arith_pkg;

  localparam int W = 4;

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  // Overflow only when both operands share a sign and the wrapped sum does not.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] raw;
    logic         ovf;
    raw = a + b;
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    if (ovf) begin
      raw = a[W-1] ? SAT_MIN : SAT_MAX;
    end
    return {raw, ovf};
  endfunction

endpackage

// File: rtl/sat_add_core.sv
// sat_add_core: combinational W-bit signed saturating adder.
//   a, b  two's-complement operands
//   sum   a + b clamped to [-2^(W-1), 2^(W-1)-1]
//   ovf   high when the clamp was applied
module sat_add_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw_sum;

  always_comb begin
    raw_sum = a + b;
    ovf     = (a[W-1] == b[W-1]) && (raw_sum[W-1] != a[W-1]);
    sum     = raw_sum;
    if (ovf) begin
      // Operand sign decides the clamp direction.
      sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/signed_sat_accumulator.sv
// signed_sat_accumulator: sums frames of FRAME_LEN signed samples with
// saturation after every addition.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous frame abort (beats arg_vld)
//   arg_vld    sample valid, always accepted
//   arg        signed sample
//   res_vld    one-cycle pulse per completed frame
//   res        saturated frame sum (held until next frame)
//   res_sat    any addition of the frame saturated (held)
//   sat_count  number of saturating additions of the frame (held)
module signed_sat_accumulator
  import sat_arith_pkg::*;
#(
  parameter int W         = sat_arith_pkg::W,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             arg_vld,
  input  logic [W-1:0]     arg,
  output logic             res_vld,
  output logic [W-1:0]     res,
  output logic             res_sat,
  output logic [CNT_W-1:0] sat_count
);

  logic [W-1:0]     acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sat_reg;
  logic [CNT_W-1:0] sat_cnt_reg;
  logic             res_vld_reg;
  logic [W-1:0]     res_reg;
  logic             res_sat_reg;
  logic [CNT_W-1:0] sat_count_reg;

  logic             accept;
  logic             last_sample;
  logic [W-1:0]     base;
  logic [W-1:0]     sum_next;
  logic             ovf;
  logic             sat_next;
  logic [CNT_W-1:0] sat_cnt_next;

  assign accept      = arg_vld && !clear;
  assign last_sample = accept && (cnt_reg == CNT_W'(FRAME_LEN - 1));
  // First sample of a frame always starts from zero.
  assign base        = (cnt_reg == '0) ? '0 : acc_reg;

  sat_add_core #(.W(W)) u_sat_add (
    .a   (base),
    .b   (arg),
    .sum (sum_next),
    .ovf (ovf)
  );

  assign sat_next     = sat_reg | ovf;
  assign sat_cnt_next = sat_cnt_reg + CNT_W'(ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      sat_reg       <= 1'b0;
      sat_cnt_reg   <= '0;
      res_vld_reg   <= 1'b0;
      res_reg       <= '0;
      res_sat_reg   <= 1'b0;
      sat_count_reg <= '0;
    end else begin
      res_vld_reg <= 1'b0;
      if (clear) begin
        acc_reg     <= '0;
        cnt_reg     <= '0;
        sat_reg     <= 1'b0;
        sat_cnt_reg <= '0;
      end else if (accept) begin
        if (last_sample) begin
          // Publish results including this step, then restart the frame.
          res_reg       <= sum_next;
          res_sat_reg   <= sat_next;
          sat_count_reg <= sat_cnt_next;
          res_vld_reg   <= 1'b1;
          acc_reg       <= '0;
          cnt_reg       <= '0;
          sat_reg       <= 1'b0;
          sat_cnt_reg   <= '0;
        end else begin
          acc_reg     <= sum_next;
          cnt_reg     <= cnt_reg + 1'b1;
          sat_reg     <= sat_next;
          sat_cnt_reg <= sat_cnt_next;
        end
      end
    end
  end

  assign res_vld   = res_vld_reg;
  assign res       = res_reg;
  assign res_sat   = res_sat_reg;
  assign sat_count = sat_count_reg;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Testbench for signed_sat_accumulator: directed frames from the test plan
// followed by random traffic, checked against an integer reference model.
module tb_signed_sat_accumulator;

  localparam int W         = 4;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int SMAX      = (1 << (W - 1)) - 1;
  localparam int SMIN      = -(1 << (W - 1));

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             arg_vld;
  logic [W-1:0]     arg;
  logic             res_vld;
  logic [W-1:0]     res;
  logic             res_sat;
  logic [CNT_W-1:0] sat_count;

  signed_sat_accumulator #(.W(W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .arg_vld   (arg_vld),
    .arg       (arg),
    .res_vld   (res_vld),
    .res       (res),
    .res_sat   (res_sat),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain integer frame sum with per-step clamping.
  int m_acc  = 0;
  int m_n    = 0;
  int m_satc = 0;
  int e_res  = 0;
  int e_sat  = 0;
  int e_cnt  = 0;
  int e_vld  = 0;
  int pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".res_vld"}, 32'(res_vld), 32'(e_vld));
    chk({tag, ".res"}, 32'(res), 32'(e_res[W-1:0]));
    chk({tag, ".res_sat"}, 32'(res_sat), 32'(e_sat[0]));
    chk({tag, ".sat_count"}, 32'(sat_count), 32'(e_cnt[CNT_W-1:0]));
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic step(input bit vld, input int val, input bit clr);
    int s;
    arg_vld = vld;
    arg     = val[W-1:0];
    clear   = clr;
    e_vld   = 0;
    if (clr) begin
      m_acc = 0; m_n = 0; m_satc = 0;
    end else if (vld) begin
      s = m_acc + val;
      if (s > SMAX) begin s = SMAX; m_satc++; end
      else if (s < SMIN) begin s = SMIN; m_satc++; end
      m_acc = s;
      m_n++;
      if (m_n == FRAME_LEN) begin
        e_res = s; e_sat = (m_satc != 0) ? 1 : 0; e_cnt = m_satc; e_vld = 1;
        m_acc = 0; m_n = 0; m_satc = 0;
      end
    end
    @(posedge clk); #1;
    if (res_vld === 1'b1) pulses++;
    chk_outputs("step");
    $display("step vld=%0d arg=%0d clr=%0d -> res_vld=%0d res=%0d sat=%0d cnt=%0d",
             vld, val, clr, res_vld, $signed(res), res_sat, sat_count);
  endtask

  task automatic pulse_reset();
    arg_vld = 0; clear = 0;
    rst_n = 0;
    #2;
    e_res = 0; e_sat = 0; e_cnt = 0; e_vld = 0;
    m_acc = 0; m_n = 0; m_satc = 0;
    chk_outputs("rst_async");
    @(posedge clk); #1;
    chk_outputs("rst_hold");
    rst_n = 1;
    $display("reset pulse applied");
  endtask

  initial begin
    int p0;
    rst_n = 0; clear = 0; arg_vld = 0; arg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset");
    rst_n = 1;

    // 1: eight 1s -> 7, one saturation.
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    chk("t1_res", 32'(res), 32'd7);
    chk("t1_cnt", 32'(sat_count), 32'd1);

    // 2: clamp then recover.
    begin
      int v2 [8] = '{7, 7, -8, 0, 0, 0, 0, 0};
      for (int i = 0; i < 8; i++) step(1, v2[i], 0);
    end
    chk("t2_res", 32'(res), 32'hF);

    // 3: eight -8 with gaps; exactly one pulse.
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      step(1, -8, 0);
      step(0, 0, 0);
    end
    chk("t3_pulses", 32'(pulses - p0), 32'd1);
    chk("t3_cnt", 32'(sat_count), 32'd7);

    // 4: back-to-back frames; sample 3 taken in the res_vld cycle.
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    chk("t4_res0", 32'(res), 32'd0);
    step(1, 3, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    chk("t4_res1", 32'(res), 32'd3);

    // 5: clear aborts a partial frame and drops its sample.
    p0 = pulses;
    for (int i = 0; i < 4; i++) step(1, 2, 0);
    step(1, 5, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    chk("t5_pulses", 32'(pulses - p0), 32'd1);
    chk("t5_res", 32'(res), 32'd7);

    // 6: reset mid-frame, then eight -1s.
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    pulse_reset();
    for (int i = 0; i < 8; i++) step(1, -1, 0);
    chk("t6_res", 32'(res), 32'h8);
    chk("t6_sat", 32'(res_sat), 32'd0);

    // Clear coinciding with the last sample: no result.
    p0 = pulses;
    for (int i = 0; i < 7; i++) step(1, 1, 0);
    step(1, 1, 1);
    step(0, 0, 0);
    chk("clr_last_pulses", 32'(pulses - p0), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit v, c;
      int a;
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 39) == 0);
      a = int'($urandom_range(0, (1 << W) - 1)) + SMIN;
      step(v, a, c);
    end

    arg_vld = 0; clear = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
